// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receive stage. Recovers frames made of one start
//   bit, DATA_WIDTH data bits sent LSB first and one stop bit, using the
//   shared 16x oversampled baudTick. Each completed frame is presented on
//   dataOut together with a one-cycle rxDone strobe and a framing-error flag.
//
// Ports
//   clk       in   system clock
//   rstN      in   asynchronous active-low reset
//   baudTick  in   one-clk enable at 16x the bit rate
//   rx        in   serial line, idle high, asynchronous to clk
//   dataOut   out  last received word (held until the next completion)
//   rxDone    out  one-clk pulse when a frame completes
//   frameErr  out  stop bit of the last completed frame was sampled low
//   rxBusy    out  high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  baudTick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rxDone,
  output logic                  frameErr,
  output logic                  rxBusy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  state_t                nextState;
  logic                  rxMeta;
  logic                  rxSync;
  logic [3:0]            tick;
  logic [CNT_W-1:0]      bitCnt;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  midStart;
  logic                  midBit;

  // Start bit is judged halfway in (8 ticks); data/stop bits are sampled a
  // full bit period (16 ticks) after the previous sample point.
  assign midStart = baudTick && (tick == 4'd7);
  assign midBit   = baudTick && (tick == 4'd15);

  // Two-flop synchronizer; resets to the idle line level so a reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!rxSync) nextState = START;
      // A start bit that is high again by its midpoint was only a glitch.
      START:   if (midStart) nextState = rxSync ? IDLE : DATA;
      DATA:    if (midBit && (bitCnt == LAST_BIT)) nextState = STOP;
      // Leave at mid stop bit so the next start edge is caught promptly,
      // even with no idle gap between frames.
      STOP:    if (midBit) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rxBusy = (state != IDLE);
  end

  // Bit timing, shift register and output registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tick     <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      dataOut  <= '0;
      frameErr <= 1'b0;
      rxDone   <= 1'b0;
    end else begin
      rxDone <= 1'b0;
      case (state)
        IDLE: begin
          tick <= '0;
        end
        START: begin
          if (midStart) begin
            tick   <= '0;
            bitCnt <= '0;
          end else if (baudTick) begin
            tick <= tick + 4'd1;
          end
        end
        DATA: begin
          if (midBit) begin
            // LSB arrives first, so shifting right from the MSB leaves the
            // word in natural order after DATA_WIDTH samples.
            shiftReg <= {rxSync, shiftReg[DATA_WIDTH-1:1]};
            tick     <= '0;
            if (bitCnt != LAST_BIT) bitCnt <= bitCnt + 1'b1;
          end else if (baudTick) begin
            tick <= tick + 4'd1;
          end
        end
        STOP: begin
          if (midBit) begin
            // The word is delivered even on a bad stop bit; the consumer
            // decides what to do with it.
            dataOut  <= shiftReg;
            frameErr <= ~rxSync;
            rxDone   <= 1'b1;
            tick     <= '0;
          end else if (baudTick) begin
            tick <= tick + 4'd1;
          end
        end
        default: begin
          tick <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the downstream counterpart of the UART transmitter on the same link.
- Shares the 16x oversampled baudTick from the baud generator.
- Recovers 8N1-style frames: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
- Presents each received word to the core-side consumer with a one-cycle done strobe and a framing-error flag.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock.
- rstN  input  1  asynchronous, active-low reset.
- baudTick  input  1  one-clk-wide enable at 16x the bit rate.
- rx  input  1  serial line; idle high; asynchronous to clk.
- dataOut  output  DATA_WIDTH  last received word.
- rxDone  output  1  one-clk pulse when a frame completes.
- frameErr  output  1  stop bit of the last completed frame sampled low.
- rxBusy  output  1  high while a frame is in progress (state != idle).

Behaviour:
- Reset:
  - Asynchronous on rstN low, all registers cleared.
  - State = idle; tick = 0; bit count = 0; shift register = 0.
  - dataOut = 0, rxDone = 0, frameErr = 0, rxBusy = 0.
  - Synchronizer flops reset to 1.
- Input sync: rx passes through a 2-flop synchronizer (rxSync); all decisions use rxSync, giving 2 clk input latency.
- Tick counter: 4 bits. Increments only on clk edges where baudTick = 1; wraps 15 -> 0. baudTick is ignored in idle.
- Bit counter: width ceil(log2(DATA_WIDTH)), minimum 1 bit.
- idle:
  - rxSync == 0 -> start, tick = 0.
  - Otherwise stay in idle.
- start:
  - On baudTick with tick == 7 (mid start bit):
    - rxSync == 0 -> data; tick = 0; count = 0.
    - rxSync == 1 -> idle (glitch rejected); no rxDone.
  - Otherwise on baudTick: tick++.
- data:
  - On baudTick with tick == 15 (mid data bit):
    - Shift register shifts right; rxSync enters the MSB, so LSB-first data lands correctly after DATA_WIDTH samples.
    - tick = 0.
    - count == DATA_WIDTH-1 -> stop; else count++.
  - Otherwise on baudTick: tick++.
- stop:
  - On baudTick with tick == 15 (mid stop bit):
    - dataOut <= shift register.
    - frameErr <= ~rxSync.
    - rxDone = 1 for exactly one clk.
    - -> idle.
  - Otherwise on baudTick: tick++.
- Output update rules:
  - dataOut and frameErr update together, only at frame completion; both hold until the next completion.
  - dataOut is updated even when frameErr = 1; the consumer decides whether to discard.
- Resynchronisation:
  - Return to idle at mid stop bit, so a following start edge is caught within the same bit period.
  - Back-to-back frames need no idle gap.
- Stop bit low (break/framing error): after completion, if rxSync stays 0 the block re-enters start immediately. The next frame is validated by the mid-start check.
- rxBusy is combinational: (state != idle).
- Reset mid-frame: frame abandoned immediately; no rxDone; dataOut keeps its reset value 0.
- No backpressure. The consumer must take dataOut within one frame time; an unread word is overwritten.

Test Plan:
- Setup for all scenarios: baudTick every 16 clk, so 1 bit = 256 clk.
- Drive frame 0xA5 with a valid stop bit -> exactly one rxDone pulse about 9.5 bit times after the start edge; dataOut = 0xA5; frameErr = 0; rxBusy high for the whole frame, then low.
- rx low for 3 baudTicks then high -> enters start, returns to idle at tick 7; rxDone never asserts; dataOut unchanged.
- Frame 0x3C with stop bit driven 0 -> rxDone pulse; dataOut = 0x3C; frameErr = 1. Next valid frame 0x11 -> frameErr = 0.
- Back-to-back 0x00 then 0xFF, zero idle gap -> two rxDone pulses one frame time apart; dataOut = 0x00 then 0xFF.
- Assert rstN low during data bit 4 of frame 0x5A -> rxBusy = 0 and no rxDone; dataOut stays 0. After release, frame 0xC3 is received correctly.
- Loopback from uart_transmitter, sharing baudTick, all 256 byte values -> every dataOut matches the sent byte; frameErr = 0 throughout.
